cache_mem_bank: RTL and testbench
=================================

# cache_mem_bank

Parametrised multi-way storage bank for the cache data/tag arrays. It holds `WAYS` independent arrays of `DEPTH` words of `WIDTH` bits each. Writes are byte-masked, reads are registered, and clearing is done by a hardware sequencer that zeroes one row per cycle. The sequencer runs after reset and on a flush request. The cache controller instantiates one bank for data (WIDTH=32) and one for tags/valid (WIDTH = tag bits + 1).

## Interface
Parameters:
- `WIDTH`, 32: word width in bits; must be a multiple of 8.
- `DEPTH`, 512: rows per way; power of two, at least 2.
- `WAYS`, 2: number of ways; 1 to 8.
- Derived: `AW = $clog2(DEPTH)`, `WW = max(1, $clog2(WAYS))`, `BW = WIDTH/8`.

Ports:
- `clk`  in  1: clock; all activity on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `flush`  in  1: request a full clear of all ways.
- `way`  in  WW: way select for the read/write.
- `addr`  in  AW: row index.
- `we`  in  1: write enable.
- `wbe`  in  BW: byte enables; bit i covers `wdata[8i+7:8i]`.
- `wdata`  in  WIDTH: write data.
- `re`  in  1: read enable.
- `rdata`  out  WIDTH: registered read data.
- `rvalid`  out  1: `rdata` is updated this cycle.
- `busy`  out  1: clear sequencer active; all requests are ignored.

## Operation
- Two states: CLEAR and IDLE.
- `rst`:
  - State goes to CLEAR and `clr_ptr` to 0.
  - `rdata` = 0, `rvalid` = 0, `busy` = 1.
  - Array contents are not touched in the reset cycle itself.
- CLEAR:
  - Each cycle, row `clr_ptr` is written to all-zero in every way, then `clr_ptr` increments.
  - When `clr_ptr == DEPTH-1` is written, the next state is IDLE and `busy` falls.
  - CLEAR therefore lasts exactly DEPTH cycles.
  - `we`, `re` and `flush` are ignored, and `rvalid` = 0.
- IDLE:
  - `flush` = 1: go to CLEAR with `clr_ptr` = 0. Any `we`/`re` in the same cycle is dropped.
  - `we` = 1: for each set bit of `wbe`, the corresponding byte of `mem[way][addr]` takes `wdata`. `wbe` = 0 makes no change.
  - `re` = 1: on the next edge, `rdata` = `mem[way][addr]` and `rvalid` = 1. With `re` = 0, `rvalid` = 0 and `rdata` holds its previous value.
  - `we` and `re` in the same cycle to the same way and row: read-first, so `rdata` returns the pre-write contents.
  - `way >= WAYS` (non-power-of-two WAYS): the write is dropped and the read returns 0 with `rvalid` = 1.
- `rst` asserted mid-CLEAR restarts the clear from row 0.
- A flush issued while `busy` = 1 is not queued.

## Timing
- Read latency: 1 cycle (request at edge n, data valid after edge n+1).
- Write is visible to a read issued in the following cycle.
- `busy` rises on the edge that samples `rst` or `flush`. It falls DEPTH edges later.
- Clear after reset: the first accepted request is in cycle DEPTH+1 after the reset edge.
- There is no asynchronous read path; `rdata` changes only on a clock edge.

## Structure
- Package `cache_mem_pkg` holds:
  - the state enum `{S_CLEAR, S_IDLE}`;
  - the derived-width helper functions (`clog2`-based `AW`/`WW`);
  - the default `WIDTH`/`DEPTH`/`WAYS` constants shared with the cache controller.
- Sub-module `cache_mem_way` is a single array with `WIDTH`/`DEPTH` parameters. It provides a byte-masked write port, a registered read port and a clear-write port. The bank instantiates it WAYS times in a generate loop and muxes read data by a registered `way`.
- The sequencer FSM and `clr_ptr` live only in `cache_mem_bank`.

## Test plan
- Reset with defaults:
  - `busy` = 1 for exactly 512 cycles, then 0.
  - Any `re` during that window gives `rvalid` = 0.
  - Afterwards, a read of way 1, row 511 returns 0x00000000.
- Byte-masked write:
  - Write 0xDEADBEEF with `wbe` = 4'b1111 to way 0, row 5.
  - Then write 0x11223344 with `wbe` = 4'b0101.
  - A read the next cycle returns 0xDE22BE44 one cycle later with `rvalid` = 1.
- Way isolation:
  - Write 0xA5A5A5A5 to way 1, row 5.
  - Way 0, row 5 still reads its old value; way 1, row 5 reads 0xA5A5A5A5.
- Read-during-write:
  - Row holds 0x1; assert `we` with 0x2 and `re` together.
  - `rdata` = 0x1; a following read returns 0x2.
- Flush:
  - Write a nonzero value to way 1, row 511 (default bank). Then assert `flush` with `we` = 1 in the same cycle.
  - The write is dropped and `busy` = 1 for 512 cycles. Every row then reads 0.
- Mid-clear reset:
  - Assert `rst` at cycle 200 of a clear.
  - `busy` stays high a further 512 cycles; row 0 reads 0.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache storage bank: sequencer states,
// width helpers and the default geometry used by the cache controller.
package cache_mem_pkg;

  localparam int CACHE_WIDTH = 32;
  localparam int CACHE_DEPTH = 512;
  localparam int CACHE_WAYS  = 2;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_e;

  // Row index width; a single-row array still needs one address bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Way select width; a single-way bank still carries a one-bit select.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_way.sv
// One storage array of the bank: byte-masked write port, registered
// read-first read port and a zeroing port used by the clear sequencer.
module cache_mem_way
  import cache_mem_pkg::*;
#(
  parameter int WIDTH = CACHE_WIDTH,
  parameter int DEPTH = CACHE_DEPTH,
  localparam int AW = addr_bits(DEPTH),
  localparam int BW = WIDTH / 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [BW-1:0]    wbe,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  output logic [WIDTH-1:0] rdata,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Read data captures the row on a read and otherwise holds its last value.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  // Array update (clear has priority) plus read register; the read sees the pre-write row.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (we) begin
      for (int b = 0; b < BW; b++) begin
        if (wbe[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cache_mem_bank.sv
// Multi-way cache storage bank. A clear sequencer zeroes one row of every
// way per cycle after reset or flush; requests are accepted only when idle.
module cache_mem_bank
  import cache_mem_pkg::*;
#(
  parameter int WIDTH = CACHE_WIDTH,
  parameter int DEPTH = CACHE_DEPTH,
  parameter int WAYS  = CACHE_WAYS,
  localparam int AW = addr_bits(DEPTH),
  localparam int WW = way_bits(WAYS),
  localparam int BW = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WW-1:0]    way,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [BW-1:0]    wbe,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             busy
);

  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);
  localparam logic [WW:0]   WAYS_L   = WAYS[WW:0];

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          busy_q, busy_d;
  logic          rvalid_q, rvalid_d;
  logic [WW-1:0] way_q, way_d;
  logic          rd_zero_q, rd_zero_d;

  logic             way_ok;
  logic             idle_ok;
  logic             rd_acc;
  logic             wr_acc;
  logic             clr_en;
  logic [WIDTH-1:0] way_rdata [WAYS];
  logic [WIDTH-1:0] rd_mux;

  assign way_ok  = ({1'b0, way} < WAYS_L);
  assign idle_ok = !rst && (state_q == S_IDLE) && !flush;
  assign rd_acc  = idle_ok && re;
  assign wr_acc  = idle_ok && we && way_ok;
  assign clr_en  = !rst && (state_q == S_CLEAR);

  // Sequencer next state: walk clr_ptr through every row, or accept a request when idle.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    rvalid_d  = 1'b0;
    way_d     = way_q;
    rd_zero_d = rd_zero_q;
    case (state_q)
      S_CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == LAST_ROW) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (flush) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end else if (re) begin
          rvalid_d  = 1'b1;
          way_d     = way;
          rd_zero_d = !way_ok;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_ptr_d = '0;
        busy_d    = 1'b1;
      end
    endcase
  end

  // Sequencer and read-select registers; reset restarts the clear from row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      rvalid_q  <= 1'b0;
      way_q     <= '0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
      rvalid_q  <= rvalid_d;
      way_q     <= way_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    logic sel;
    assign sel = (way == WW'(i));

    cache_mem_way #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_way (
      .clk      (clk),
      .we       (wr_acc && sel),
      .wbe      (wbe),
      .addr     (addr),
      .wdata    (wdata),
      .re       (rd_acc && sel),
      .rdata    (way_rdata[i]),
      .clr_en   (clr_en),
      .clr_addr (clr_ptr_q)
    );
  end

  // Select the way captured with the last read; unselected ways keep their own registers.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (way_q == WW'(i)) begin
        rd_mux = way_rdata[i];
      end
    end
  end

  assign rdata  = rd_zero_q ? '0 : rd_mux;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_cache_mem_bank.sv
// Directed scoreboard bench for cache_mem_bank with the default geometry.
// Reads push their hand-computed result; a negedge monitor pops and compares.
module tb_cache_mem_bank;

  localparam int WIDTH = 32;
  localparam int DEPTH = 512;
  localparam int WAYS  = 2;
  localparam int AW    = 9;
  localparam int WW    = 1;
  localparam int BW    = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [WW-1:0]    way;
  logic [AW-1:0]    addr;
  logic             we;
  logic [BW-1:0]    wbe;
  logic [WIDTH-1:0] wdata;
  logic             re;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             busy;

  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit               mon_en   = 1'b0;

  cache_mem_bank #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .WAYS (WAYS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .way    (way),
    .addr   (addr),
    .we     (we),
    .wbe    (wbe),
    .wdata  (wdata),
    .re     (re),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One counted comparison; any difference prints a FAIL line.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every cycle an rvalid is owed exactly when the scoreboard holds an entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        checkOutput("rvalid_on_read", {31'b0, rvalid}, 32'd1);
        checkOutput("rdata", rdata, exp_q.pop_front());
      end else begin
        checkOutput("rvalid_quiet", {31'b0, rvalid}, 32'd0);
      end
    end
  end

  // Drive one request for a single clock; a read response is owed after that edge.
  task automatic applyStimulus(input logic f, input logic w, input logic r,
                               input logic [WW-1:0] wy, input logic [AW-1:0] a,
                               input logic [BW-1:0] be, input logic [WIDTH-1:0] d,
                               input bit push, input logic [WIDTH-1:0] expv);
    flush = f; we = w; re = r; way = wy; addr = a; wbe = be; wdata = d;
    @(posedge clk);
    if (push) exp_q.push_back(expv);
    #1;
    flush = 1'b0; we = 1'b0; re = 1'b0; wbe = '0; wdata = '0;
  endtask

  task automatic doWrite(input logic [WW-1:0] wy, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [WIDTH-1:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, wy, a, be, d, 1'b0, '0);
  endtask

  task automatic doRead(input logic [WW-1:0] wy, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] expv);
    applyStimulus(1'b0, 1'b0, 1'b1, wy, a, '0, '0, 1'b1, expv);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges until busy drops, bounded so a stuck sequencer still ends the run.
  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n1;
    int n2;
    rst = 1'b1; flush = 1'b0; way = '0; addr = '0;
    we = 1'b0; wbe = '0; wdata = '0; re = 1'b0;

    // Reset state and clear length; reads during the clear must stay silent.
    pulseReset();
    mon_en = 1'b1;
    checkOutput("reset_busy", {31'b0, busy}, 32'd1);
    checkOutput("reset_rdata", rdata, 32'd0);
    re = 1'b1; way = 1'b1; addr = 9'd3;
    waitIdle(n1);
    re = 1'b0;
    checkOutput("reset_clear_cycles", n1, 32'd512);
    doRead(1'b1, 9'd511, 32'h0000_0000);

    // Byte-masked merge.
    doWrite(1'b0, 9'd5, 4'b1111, 32'hDEAD_BEEF);
    doWrite(1'b0, 9'd5, 4'b0101, 32'h1122_3344);
    doRead(1'b0, 9'd5, 32'hDE22_BE44);

    // Way isolation.
    doWrite(1'b1, 9'd5, 4'b1111, 32'hA5A5_A5A5);
    doRead(1'b0, 9'd5, 32'hDE22_BE44);
    doRead(1'b1, 9'd5, 32'hA5A5_A5A5);

    // Empty byte mask leaves the row alone.
    doWrite(1'b0, 9'd5, 4'b0000, 32'h0000_0000);
    doRead(1'b0, 9'd5, 32'hDE22_BE44);

    // Read-during-write returns the old contents.
    doWrite(1'b0, 9'd7, 4'b1111, 32'h0000_0001);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 9'd7, 4'b1111, 32'h0000_0002, 1'b1, 32'h0000_0001);
    doRead(1'b0, 9'd7, 32'h0000_0002);

    // rdata holds its value across a cycle without a read.
    tick(1);
    checkOutput("rdata_hold", rdata, 32'h0000_0002);

    // Flush with a simultaneous write and read; a second flush mid-clear is ignored.
    doWrite(1'b1, 9'd511, 4'b1111, 32'hCAFE_F00D);
    doRead(1'b1, 9'd511, 32'hCAFE_F00D);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 9'd511, 4'b1111, 32'h1234_5678, 1'b0, '0);
    checkOutput("flush_busy", {31'b0, busy}, 32'd1);
    tick(99);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, '0, '0, 1'b0, '0);
    waitIdle(n2);
    checkOutput("flush_clear_cycles", 100 + n2, 32'd512);
    for (int w = 0; w < WAYS; w++) begin
      for (int r = 0; r < DEPTH; r++) begin
        doRead(WW'(w), AW'(r), 32'h0000_0000);
      end
    end

    // Reset in the middle of a clear restarts it from row 0.
    doWrite(1'b0, 9'd0, 4'b1111, 32'h7777_7777);
    doRead(1'b0, 9'd0, 32'h7777_7777);
    pulseReset();
    tick(199);
    pulseReset();
    checkOutput("midclear_rdata", rdata, 32'd0);
    waitIdle(n1);
    checkOutput("midclear_cycles", n1, 32'd512);
    doRead(1'b0, 9'd0, 32'h0000_0000);

    tick(2);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
